// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the K580VT57 (i8257) DMA controller.
package k580vt57_pkg;

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4} state_t;

  localparam logic [1:0] XFER_VERIFY = 2'b00;
  localparam logic [1:0] XFER_WRITE  = 2'b01;
  localparam logic [1:0] XFER_READ   = 2'b10;

  localparam int MODE_ROT    = 4;
  localparam int MODE_EXTW   = 5;
  localparam int MODE_TCSTOP = 6;
  localparam int MODE_AUTO   = 7;

  localparam int STAT_TC0 = 0;
  localparam int STAT_UPD = 4;

  function automatic logic [15:0] put_byte(input logic [15:0] old, input logic hi,
                                           input logic [7:0] b);
    return hi ? {b, old[7:0]} : {old[15:8], b};
  endfunction

endpackage

// File: rtl/k580vt57_if.sv
// CPU register bus plus DMA request/strobe bundle of the K580VT57.
interface k580vt57_if;
  logic        ce;
  logic [3:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n;
  logic        ird_n;
  logic [3:0]  drq;
  logic [3:0]  dack;
  logic        hrq;
  logic        hlda;
  logic [15:0] oaddr;
  logic        memr_n;
  logic        memw_n;
  logic        ior_n;
  logic        iow_n;
  logic        tc;
  logic        mark;
  logic        aen;

  // master: CPU/system side; slave: the DMA controller's register port
  modport master (output ce, iaddr, idata, iwe_n, ird_n, drq, hlda,
                  input  odata, dack, hrq, oaddr, memr_n, memw_n, ior_n, iow_n, tc, mark, aen);
  modport slave  (input  ce, iaddr, idata, iwe_n, ird_n, drq, hlda,
                  output odata, dack, hrq, oaddr, memr_n, memw_n, ior_n, iow_n, tc, mark, aen);
endinterface

// File: rtl/k580vt57_prio.sv
// Four-way request arbiter: fixed (ch0 highest) or rotating after the last grant.
module k580vt57_prio (
  input  logic [3:0] pend_i,
  input  logic       rot_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o
);
  logic [1:0] idx;

  // Walk from lowest to highest priority so the highest pending one wins last.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rot_i ? last_i + 2'(i + 1) : 2'(i);
      if (pend_i[idx]) gnt_o = 4'b0001 << idx;
    end
  end
endmodule

// File: rtl/k580vt57.sv
// K580VT57 DMA controller top. Optional ch2<-ch3 autoload: define K580VT57_AUTOLOAD_EN.
module k580vt57 import k580vt57_pkg::*; #(
  parameter int NCH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  k580vt57_if.slave  bus
);
`ifdef K580VT57_AUTOLOAD_EN
  localparam bit AutoEn = 1'b1;
`else
  localparam bit AutoEn = 1'b0;
`endif

  if (NCH != 4) begin : g_nch_chk
    $error("k580vt57: NCH must be 4");
  end

  logic [15:0] addr_q [4], addr_d [4], cnt_q [4], cnt_d [4];
  logic [7:0]  mode_q, mode_d, odata_q, rd_mux;
  logic [3:0]  tcf_q, tcf_d, frst_q, frst_d, pend, gnt, dack_q;
  logic        ff_q, ff_d, upd_q, upd_d, we_dly_q, rd_dly_q;
  logic        pw_vld_q, pw_hi_q;
  logic [2:0]  pw_reg_q;
  logic [7:0]  pw_dat_q;
  state_t      st_q;
  logic [1:0]  ch_q, last_q, gch, xtyp;
  logic        hrq_q, aen_q, tc_q, mark_q, memr_n_q, memw_n_q, ior_n_q, iow_n_q;
  logic [15:0] oaddr_q;
  logic        wr_stb, rd_stb, busy, upd_tick, s4_tick, tc_now, reload, defer, go_s1;
  logic        wv [2];
  logic [2:0]  wreg [2];
  logic        wh [2];
  logic [7:0]  wdat [2];

  assign pend = bus.drq & mode_q[3:0];
  k580vt57_prio u_prio (.pend_i(pend), .rot_i(mode_q[MODE_ROT]), .last_i(last_q), .gnt_o(gnt));
  assign gch = {gnt[3] | gnt[2], gnt[3] | gnt[1]};

  assign wr_stb   = bus.iwe_n & ~we_dly_q;
  assign rd_stb   = bus.ird_n & ~rd_dly_q;
  assign busy     = (st_q != IDLE) && (st_q != S0);
  assign upd_tick = bus.ce && (st_q == S3);
  assign s4_tick  = bus.ce && (st_q == S4);
  assign tc_now   = (cnt_q[ch_q][13:0] == 14'd0);
  assign xtyp     = cnt_q[ch_q][15:14];
  assign reload   = AutoEn && upd_tick && tc_now && (ch_q == 2'd2) && mode_q[MODE_AUTO];
  // A CPU write to the channel mid-cycle is parked and lands after the S4 update.
  assign defer    = wr_stb && !bus.iaddr[3] && busy && !s4_tick && (bus.iaddr[2:1] == ch_q);
  assign go_s1    = bus.ce && bus.hlda &&
                    (((st_q == S0) && (|pend)) || ((st_q == S4) && pend[ch_q]));

  always_comb begin
    wv[0]   = pw_vld_q && (!busy || s4_tick);
    wreg[0] = pw_reg_q;
    wh[0]   = pw_hi_q;
    wdat[0] = pw_dat_q;
    wv[1]   = wr_stb && !bus.iaddr[3] && !defer;
    wreg[1] = bus.iaddr[2:0];
    wh[1]   = ff_q;
    wdat[1] = bus.idata;
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    frst_d = frst_q;
    ff_d   = ff_q;
    upd_d  = bus.ce ? 1'b0 : upd_q;
    tcf_d  = (rd_stb && bus.iaddr == 4'd8) ? 4'h0 : tcf_q;
    if (upd_tick) begin
      addr_d[ch_q] = addr_q[ch_q] + 16'd1;
      cnt_d[ch_q]  = {cnt_q[ch_q][15:14], cnt_q[ch_q][13:0] - 14'd1};
      frst_d[ch_q] = 1'b0;
      if (tc_now) begin
        tcf_d[ch_q] = 1'b1;
        if (mode_q[MODE_TCSTOP] && !reload) mode_d[{1'b0, ch_q}] = 1'b0;
      end
      if (reload) begin
        addr_d[2] = addr_q[3];
        cnt_d[2]  = cnt_q[3];
        upd_d     = 1'b1;
      end
    end
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 4; c++)
        if (wv[1'(s)] && ((wreg[1'(s)][2:1] == 2'(c)) ||
            (AutoEn && mode_q[MODE_AUTO] && c == 3 && wreg[1'(s)][2:1] == 2'd2))) begin
          if (wreg[1'(s)][0]) begin
            cnt_d[2'(c)]  = put_byte(cnt_d[2'(c)], wh[1'(s)], wdat[1'(s)]);
            frst_d[2'(c)] = 1'b1;
          end else begin
            addr_d[2'(c)] = put_byte(addr_d[2'(c)], wh[1'(s)], wdat[1'(s)]);
          end
        end
    if (wr_stb && bus.iaddr == 4'd8) begin
      mode_d = bus.idata;
      ff_d   = 1'b0;
    end else if (wr_stb && !bus.iaddr[3]) begin
      ff_d = ~ff_q;
    end
    if (rd_stb && !bus.iaddr[3]) ff_d = ~ff_d;
  end

  always_comb begin
    rd_mux = '0;
    if (bus.iaddr == 4'd8) begin
      rd_mux[STAT_TC0 +: 4] = tcf_q;
      rd_mux[STAT_UPD]      = upd_q;
    end else if (!bus.iaddr[3]) begin
      if (bus.iaddr[0]) rd_mux = ff_q ? cnt_q[bus.iaddr[2:1]][15:8]  : cnt_q[bus.iaddr[2:1]][7:0];
      else              rd_mux = ff_q ? addr_q[bus.iaddr[2:1]][15:8] : addr_q[bus.iaddr[2:1]][7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '{default: '0};
      cnt_q    <= '{default: '0};
      mode_q   <= '0;
      tcf_q    <= '0;
      frst_q   <= '0;
      ff_q     <= 1'b0;
      upd_q    <= 1'b0;
      we_dly_q <= 1'b1;
      rd_dly_q <= 1'b1;
      odata_q  <= '0;
      pw_vld_q <= 1'b0;
      pw_reg_q <= '0;
      pw_hi_q  <= 1'b0;
      pw_dat_q <= '0;
    end else begin
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      tcf_q    <= tcf_d;
      frst_q   <= frst_d;
      ff_q     <= ff_d;
      upd_q    <= upd_d;
      we_dly_q <= bus.iwe_n;
      rd_dly_q <= bus.ird_n;
      if (!bus.ird_n) odata_q <= rd_mux;
      if (defer) begin
        pw_vld_q <= 1'b1;
        pw_reg_q <= bus.iaddr[2:0];
        pw_hi_q  <= ff_q;
        pw_dat_q <= bus.idata;
      end else if (wv[0]) begin
        pw_vld_q <= 1'b0;
      end
    end
  end

  // Bus-cycle sequencer; every output is registered on entry to its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= IDLE;  hrq_q <= 1'b0;  aen_q <= 1'b0;  dack_q <= '0;  oaddr_q <= '0;
      tc_q <= 1'b0;  mark_q <= 1'b0; ch_q <= '0;     last_q <= '0;
      memr_n_q <= 1'b1;  memw_n_q <= 1'b1;  ior_n_q <= 1'b1;  iow_n_q <= 1'b1;
    end else if (bus.ce) begin
      case (st_q)
        IDLE: if (|pend) begin
          st_q  <= S0;
          hrq_q <= 1'b1;
        end
        S0: if (!(|pend)) begin
          st_q  <= IDLE;
          hrq_q <= 1'b0;
        end
        S1: begin
          st_q     <= S2;
          memr_n_q <= !(xtyp == XFER_READ);
          ior_n_q  <= !(xtyp == XFER_WRITE);
          memw_n_q <= !(mode_q[MODE_EXTW] && xtyp == XFER_WRITE);
          iow_n_q  <= !(mode_q[MODE_EXTW] && xtyp == XFER_READ);
        end
        S2: begin
          st_q     <= S3;
          memw_n_q <= !(xtyp == XFER_WRITE);
          iow_n_q  <= !(xtyp == XFER_READ);
        end
        S3: begin
          st_q <= S4;
          memr_n_q <= 1'b1;  memw_n_q <= 1'b1;  ior_n_q <= 1'b1;  iow_n_q <= 1'b1;
        end
        S4: if (!go_s1) begin
          st_q <= IDLE;  hrq_q <= 1'b0;  aen_q <= 1'b0;  dack_q <= '0;
          tc_q <= 1'b0;  mark_q <= 1'b0;
        end
        default: st_q <= IDLE;
      endcase
      if (go_s1) begin
        st_q    <= S1;
        ch_q    <= gch;
        last_q  <= gch;
        aen_q   <= 1'b1;
        dack_q  <= gnt;
        oaddr_q <= addr_d[gch];
        tc_q    <= (cnt_d[gch][13:0] == 14'd0);
        mark_q  <= (cnt_d[gch][6:0] == 7'd0) && !frst_d[gch];
      end
    end
  end

  assign bus.odata  = odata_q;
  assign bus.dack   = dack_q;
  assign bus.hrq    = hrq_q;
  assign bus.aen    = aen_q;
  assign bus.oaddr  = oaddr_q;
  assign bus.memr_n = memr_n_q;
  assign bus.memw_n = memw_n_q;
  assign bus.ior_n  = ior_n_q;
  assign bus.iow_n  = iow_n_q;
  assign bus.tc     = tc_q;
  assign bus.mark   = mark_q;
endmodule

// File: tb/tb_k580vt57.sv
// Directed bench for the K580VT57 DMA controller; hlda follows hrq.
module tb_k580vt57;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  k580vt57_if b ();
  k580vt57 #(.NCH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(b));

  int n_chk = 0;
  int n_bad = 0;
  int n_memw = 0;
  int n_iow = 0;
  int nm;
  logic hlda_en = 1'b1;
  logic rs_prev = 1'b0, mw_prev = 1'b0, iw_prev = 1'b0;
  logic [15:0] q_addr [$];
  logic [3:0]  q_dack [$];
  logic        q_tc [$];
  logic        q_mark [$];
  logic        q_memr [$];
  logic [7:0]  rdv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // hlda model and per-cycle recorder keyed on the read-strobe leading edge
  always @(negedge clk) begin : mon
    logic rs;
    b.hlda = hlda_en & b.hrq;
    rs = !b.memr_n || !b.ior_n;
    if (rs && !rs_prev) begin
      q_addr.push_back(b.oaddr);
      q_dack.push_back(b.dack);
      q_tc.push_back(b.tc);
      q_mark.push_back(b.mark);
      q_memr.push_back(!b.memr_n);
    end
    if (!b.memw_n && !mw_prev) n_memw++;
    if (!b.iow_n && !iw_prev) n_iow++;
    rs_prev = rs;
    mw_prev = !b.memw_n;
    iw_prev = !b.iow_n;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    b.iaddr = a; b.idata = d; b.iwe_n = 1'b0;
    tick(2);
    b.iwe_n = 1'b1;
    tick(1);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    b.iaddr = a; b.ird_n = 1'b0;
    tick(2);
    d = b.odata;
    b.ird_n = 1'b1;
    tick(1);
  endtask

  task automatic prog(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] c);
    cpu_wr({1'b0, ch, 1'b0}, a[7:0]);
    cpu_wr({1'b0, ch, 1'b0}, a[15:8]);
    cpu_wr({1'b0, ch, 1'b1}, c[7:0]);
    cpu_wr({1'b0, ch, 1'b1}, c[15:8]);
  endtask

  task automatic do_reset();
    b.drq = 4'h0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    q_addr.delete(); q_dack.delete(); q_tc.delete(); q_mark.delete(); q_memr.delete();
    n_memw = 0; n_iow = 0;
  endtask

  task automatic wait_dma(input int budget, input string tag);
    int n = 0;
    while (!b.hrq && n < budget) begin tick(1); n++; end
    while (b.hrq && n < budget) begin tick(1); n++; end
    chk({tag, "_done"}, 32'(n < budget), 1);
  endtask

  task automatic wait_recs(input int k, input int budget, input string tag);
    int n = 0;
    while (q_addr.size() < k && n < budget) begin tick(1); n++; end
    chk({tag, "_recs"}, 32'(n < budget), 1);
  endtask

  initial begin
    b.ce = 1'b1; b.iaddr = '0; b.idata = '0; b.iwe_n = 1'b1; b.ird_n = 1'b1; b.drq = '0;
    reset_n = 1'b0;
    tick(2);
    chk("rst_dack", b.dack, 0);    chk("rst_hrq", b.hrq, 0);     chk("rst_aen", b.aen, 0);
    chk("rst_strb", {b.memr_n, b.memw_n, b.ior_n, b.iow_n}, 4'hF);
    chk("rst_oaddr", b.oaddr, 0);  chk("rst_tcmk", {b.tc, b.mark}, 0);  chk("rst_odata", b.odata, 0);
    do_reset();

    // read-to-IO burst of 5 bytes with TC stop
    prog(2'd2, 16'h76D0, 16'h8004);
    cpu_wr(4'd8, 8'h44);
    b.drq = 4'b0100;
    wait_dma(400, "t1");
    b.drq = 4'b0000;
    chk("t1_n", q_addr.size(), 5);
    chk("t1_a0", q_addr[0], 16'h76D0);  chk("t1_a4", q_addr[4], 16'h76D4);
    chk("t1_dack", q_dack[2], 4'b0100);
    chk("t1_tc", {q_tc[0], q_tc[1], q_tc[2], q_tc[3], q_tc[4]}, 5'b00001);
    chk("t1_mark", {q_mark[0], q_mark[3], q_mark[4]}, 3'b001);
    chk("t1_memr", q_memr[0], 1);
    chk("t1_iow", n_iow, 5);  chk("t1_memw", n_memw, 0);
    cpu_rd(4'd8, rdv);  chk("t1_stat1", rdv, 8'h04);
    cpu_rd(4'd8, rdv);  chk("t1_stat2", rdv, 8'h00);
    cpu_rd(4'd4, rdv);  chk("t1_alo", rdv, 8'hD5);
    cpu_rd(4'd4, rdv);  chk("t1_ahi", rdv, 8'h76);
    cpu_rd(4'd5, rdv);  chk("t1_clo", rdv, 8'hFF);
    cpu_rd(4'd5, rdv);  chk("t1_chi", rdv, 8'hBF);
    b.drq = 4'b0100;
    tick(20);
    chk("t1_disabled", b.hrq, 0);

    // request drops after two bytes, then resumes
    do_reset();
    prog(2'd2, 16'h76D0, 16'h8004);
    cpu_wr(4'd8, 8'h44);
    b.drq = 4'b0100;
    wait_recs(2, 200, "t2a");
    b.drq = 4'b0000;
    wait_dma(200, "t2a");
    chk("t2_n2", q_addr.size(), 2);
    chk("t2_hrq", b.hrq, 0);
    b.drq = 4'b0100;
    wait_dma(400, "t2b");
    b.drq = 4'b0000;
    chk("t2_n5", q_addr.size(), 5);
    chk("t2_resume", q_addr[2], 16'h76D2);

    // fixed priority: ch0 before ch2
    do_reset();
    prog(2'd0, 16'h1000, 16'h8001);
    prog(2'd2, 16'h2000, 16'h8001);
    cpu_wr(4'd8, 8'h05);
    b.drq = 4'b0101;
    wait_recs(1, 200, "t3f");
    b.drq = 4'b0000;
    wait_dma(200, "t3f");
    chk("t3_fixed", q_dack[0], 4'b0001);
    chk("t3_faddr", q_addr[0], 16'h1000);

    // rotating priority from reset (last=0): ch2, ch0, ch2, ch0
    do_reset();
    prog(2'd0, 16'h1000, 16'h8001);
    prog(2'd2, 16'h2000, 16'h8001);
    cpu_wr(4'd8, 8'h15);
    b.drq = 4'b0101;
    wait_recs(4, 400, "t3r");
    b.drq = 4'b0000;
    wait_dma(200, "t3r");
    chk("t3_rn", q_addr.size(), 4);
    chk("t3_rot", {q_dack[0], q_dack[1], q_dack[2], q_dack[3]}, 16'h4141);
    chk("t3_raddr", {q_addr[0], q_addr[1]}, 32'h2000_1000);
    chk("t3_raddr2", {q_addr[2], q_addr[3]}, 32'h2001_1001);

    // 256-byte IO-to-memory block: marks at counts 0x80 and 0x00
    do_reset();
    prog(2'd0, 16'h3000, 16'h40FF);
    cpu_wr(4'd8, 8'h41);
    b.drq = 4'b0001;
    wait_dma(3000, "t4");
    b.drq = 4'b0000;
    chk("t4_n", q_addr.size(), 256);
    chk("t4_ior", q_memr[0], 0);
    chk("t4_memw", n_memw, 256);  chk("t4_iow", n_iow, 0);
    nm = 0;
    foreach (q_mark[i]) nm += int'(q_mark[i]);
    chk("t4_nmark", nm, 2);
    chk("t4_mark", {q_mark[126], q_mark[127], q_mark[128], q_mark[255]}, 4'b0101);
    chk("t4_tc", {q_tc[254], q_tc[255]}, 2'b01);
    chk("t4_last", q_addr[255], 16'h30FF);

    // autoload of ch2 from ch3
    do_reset();
    prog(2'd2, 16'h0500, 16'h8001);
    prog(2'd3, 16'h1000, 16'h8001);
    cpu_wr(4'd8, 8'hC4);
    b.drq = 4'b0100;
`ifdef K580VT57_AUTOLOAD_EN
    wait_recs(4, 400, "t5");
    b.drq = 4'b0000;
    wait_dma(200, "t5");
    chk("t5_n", q_addr.size(), 4);
    chk("t5_a1", q_addr[1], 16'h0501);
    chk("t5_reload", {q_addr[2], q_addr[3]}, 32'h1000_1001);
`else
    wait_dma(400, "t5");
    chk("t5_n", q_addr.size(), 2);
    cpu_rd(4'd8, rdv);  chk("t5_stat", rdv, 8'h04);
    tick(20);
    chk("t5_stopped", b.hrq, 0);
    b.drq = 4'b0000;
`endif

    // asynchronous reset while the read strobe is active
    do_reset();
    prog(2'd2, 16'h76D0, 16'h8004);
    cpu_wr(4'd8, 8'h04);
    b.drq = 4'b0100;
    begin
      int n = 0;
      while (b.memr_n && n < 200) begin tick(1); n++; end
      chk("t6_s2", 32'(n < 200), 1);
    end
    reset_n = 1'b0;
    #1;
    chk("t6_strb", {b.memr_n, b.memw_n, b.ior_n, b.iow_n}, 4'hF);
    chk("t6_dack", b.dack, 0);  chk("t6_aen", {b.aen, b.hrq}, 0);  chk("t6_oaddr", b.oaddr, 0);
    b.drq = 4'b0000;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    cpu_rd(4'd4, rdv);  chk("t6_alo", rdv, 8'h00);
    cpu_rd(4'd5, rdv);  chk("t6_clo", rdv, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
